// File: rtl/riscv_pkg.sv
// Shared types for the data-memory responder.
// Size encodings, FSM states and lane helpers.
package riscv_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } dmr_state_e;

  function automatic logic [3:0] lane_mask(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    logic [3:0] m;
    m = 4'b0000;
    unique case (1'b1)
      (sz == SZ_BYTE): m = 4'b0001 << a;
      (sz == SZ_HALF): m = a[1] ? 4'b1100 : 4'b0011;
      default:         m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage request/response bundle.
// master = pipeline side, slave = responder side.
interface data_mem_responder_if;

  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_err, stall
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata,
    output resp_err, stall
  );

endinterface

// File: rtl/dmem_array.sv
// Byte-lane-enabled 32-bit word storage.
// Asynchronous read, contents never reset.
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [DEPTH];

  // write only the enabled byte lanes
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = r_mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency load/store responder for the MEM stage.
// Checks legality, writes lanes, extends load data.
module data_mem_responder
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input logic clk,
  input logic rst,
  data_mem_responder_if.slave bus
);

  localparam int AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT = 4'(LATENCY);
  localparam logic [32:0] LIMIT = 33'(4 * DEPTH_WORDS);

  dmr_state_e  r_state;
  dmr_state_e  w_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        w_enter;

  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_idle;
  logic        w_acc;
  logic        w_we;
  logic [1:0]  w_size;
  logic        w_uns;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_err;
  logic [3:0]  w_be;
  logic [31:0] w_wlanes;
  logic [31:0] w_rword;
  logic [31:0] w_shift;
  logic [31:0] w_ext;

  assign w_idle = (r_state == S_IDLE);
  assign w_acc  = w_idle && bus.req_valid;

  // in IDLE the live request is used so LATENCY==1 can
  // write/read on the acceptance edge itself
  assign w_we    = w_idle ? bus.req_we       : r_we;
  assign w_size  = w_idle ? bus.req_size     : r_size;
  assign w_uns   = w_idle ? bus.req_unsigned : r_uns;
  assign w_addr  = w_idle ? bus.req_addr     : r_addr;
  assign w_wdata = w_idle ? bus.req_wdata    : r_wdata;

  // legality: size, alignment, range
  always_comb begin
    w_err = 1'b0;
    unique case (1'b1)
      (w_size == SZ_BYTE): w_err = 1'b0;
      (w_size == SZ_HALF): w_err = w_addr[0];
      (w_size == SZ_WORD): w_err = |w_addr[1:0];
      default:             w_err = 1'b1;
    endcase
    if ({1'b0, w_addr} >= LIMIT) w_err = 1'b1;
  end

  // state register and latency counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // next state, counter and RESP-entry strobe
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_enter    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (LAT == 4'd1) begin
            w_next     = S_RESP;
            w_cnt_next = 4'd0;
            w_enter    = rst;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = LAT - 4'd1;
          end
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_next  = S_RESP;
          w_enter = rst;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // capture the request at acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_size  <= SZ_BYTE;
      r_uns   <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else if (w_acc) begin
      r_we    <= bus.req_we;
      r_size  <= bus.req_size;
      r_uns   <= bus.req_unsigned;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
    end
  end

  assign w_be = (w_enter && w_we && !w_err)
              ? lane_mask(w_size, w_addr[1:0])
              : 4'b0000;

  // replicate so every lane sees the right slice
  always_comb begin
    w_wlanes = w_wdata;
    unique case (1'b1)
      (w_size == SZ_BYTE): w_wlanes = {4{w_wdata[7:0]}};
      (w_size == SZ_HALF): w_wlanes = {2{w_wdata[15:0]}};
      default:             w_wlanes = w_wdata;
    endcase
  end

  dmem_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (w_be),
    .addr  (w_addr[AW+1:2]),
    .wdata (w_wlanes),
    .rdata (w_rword)
  );

  assign w_shift = w_rword >> {w_addr[1:0], 3'b000};

  // sign/zero extension of the addressed bytes
  always_comb begin
    w_ext = w_shift;
    unique case (1'b1)
      (w_size == SZ_BYTE):
        w_ext = {{24{~w_uns & w_shift[7]}},
                 w_shift[7:0]};
      (w_size == SZ_HALF):
        w_ext = {{16{~w_uns & w_shift[15]}},
                 w_shift[15:0]};
      default: w_ext = w_shift;
    endcase
  end

  // response data held stable through RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_enter) begin
      r_err   <= w_err;
      r_rdata <= (w_err || w_we) ? 32'd0 : w_ext;
    end
  end

  assign bus.req_ready  = w_idle;
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_rdata = bus.resp_valid ? r_rdata : 32'd0;
  assign bus.resp_err   = bus.resp_valid & r_err;
  assign bus.stall      = bus.req_valid & ~bus.resp_valid;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder (LATENCY 1 and 2).
// Byte-array reference model, table plus random.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic t_rst = 1'b0;
  logic t_valid = 1'b0;
  logic t_we = 1'b0;
  logic [1:0] t_size = 2'b00;
  logic t_uns = 1'b0;
  logic [31:0] t_addr = 32'd0;
  logic [31:0] t_wdata = 32'd0;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] mdl [2][1024];

  always #5 clk = ~clk;

  data_mem_responder_if b1 ();
  data_mem_responder_if b2 ();

  assign b1.req_valid    = t_valid;
  assign b1.req_we       = t_we;
  assign b1.req_size     = t_size;
  assign b1.req_unsigned = t_uns;
  assign b1.req_addr     = t_addr;
  assign b1.req_wdata    = t_wdata;
  assign b2.req_valid    = t_valid;
  assign b2.req_we       = t_we;
  assign b2.req_size     = t_size;
  assign b2.req_unsigned = t_uns;
  assign b2.req_addr     = t_addr;
  assign b2.req_wdata    = t_wdata;

  data_mem_responder #(
    .DEPTH_WORDS (256),
    .LATENCY     (1)
  ) u1 (
    .clk (clk),
    .rst (t_rst),
    .bus (b1)
  );

  data_mem_responder #(
    .DEPTH_WORDS (256),
    .LATENCY     (2)
  ) u2 (
    .clk (clk),
    .rst (t_rst),
    .bus (b2)
  );

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int w);
    return (32'h9E3779B9 * w) ^ 32'hA5A5A5A5;
  endfunction

  function automatic logic mdl_legal(
    input logic [1:0] sz,
    input logic [31:0] a
  );
    int nb;
    if (sz == 2'b11) return 1'b0;
    nb = 1 << sz;
    if ((a % nb) != 0) return 1'b0;
    return (a < 32'd1024);
  endfunction

  // returns {err, rdata} for DUT d from the byte model
  function automatic logic [32:0] ref_resp(
    input int d,
    input logic we,
    input logic [1:0] sz,
    input logic un,
    input logic [31:0] a
  );
    logic [31:0] v;
    int nb;
    if (!mdl_legal(sz, a)) return {1'b1, 32'd0};
    if (we) return {1'b0, 32'd0};
    nb = 1 << sz;
    v = 32'd0;
    for (int i = 0; i < nb; i++)
      v[8*i +: 8] = mdl[d][int'(a) + i];
    if (!un && nb == 1 && v[7]) v[31:8] = '1;
    if (!un && nb == 2 && v[15]) v[31:16] = '1;
    return {1'b0, v};
  endfunction

  task automatic mdl_store(
    input int d,
    input logic [1:0] sz,
    input logic [31:0] a,
    input logic [31:0] wd
  );
    int nb;
    nb = 1 << sz;
    for (int i = 0; i < nb; i++)
      mdl[d][int'(a) + i] = wd[8*i +: 8];
  endtask

  task automatic do_req(
    input logic we,
    input logic [1:0] sz,
    input logic un,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [31:0] e1,
    input logic e1e,
    input logic [31:0] e2,
    input logic e2e,
    input string nm
  );
    @(negedge clk);
    t_valid = 1'b1;
    t_we = we;
    t_size = sz;
    t_uns = un;
    t_addr = a;
    t_wdata = wd;
    #1;
    chk({nm, " rdy2"}, 32'(b2.req_ready), 32'd1);
    chk({nm, " stall2"}, 32'(b2.stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    t_valid = 1'b0;
    t_we = 1'($urandom);
    t_size = 2'($urandom);
    t_addr = $urandom;
    t_wdata = $urandom;
    #1;
    chk({nm, " v1"}, 32'(b1.resp_valid), 32'd1);
    chk({nm, " d1"}, b1.resp_rdata, e1);
    chk({nm, " e1"}, 32'(b1.resp_err), 32'(e1e));
    chk({nm, " v2wait"}, 32'(b2.resp_valid), 32'd0);
    chk({nm, " rdy2wait"}, 32'(b2.req_ready), 32'd0);
    @(negedge clk);
    #1;
    chk({nm, " v1off"}, 32'(b1.resp_valid), 32'd0);
    chk({nm, " v2"}, 32'(b2.resp_valid), 32'd1);
    chk({nm, " d2"}, b2.resp_rdata, e2);
    chk({nm, " e2"}, 32'(b2.resp_err), 32'(e2e));
    @(negedge clk);
    #1;
    chk({nm, " v2off"}, 32'(b2.resp_valid), 32'd0);
    chk({nm, " rdy2idle"}, 32'(b2.req_ready), 32'd1);
    if (we && mdl_legal(sz, a)) begin
      mdl_store(0, sz, a, wd);
      mdl_store(1, sz, a, wd);
    end
  endtask

  task automatic do_ref(
    input logic we,
    input logic [1:0] sz,
    input logic un,
    input logic [31:0] a,
    input logic [31:0] wd,
    input string nm
  );
    logic [32:0] r1;
    logic [32:0] r2;
    r1 = ref_resp(0, we, sz, un, a);
    r2 = ref_resp(1, we, sz, un, a);
    do_req(we, sz, un, a, wd, r1[31:0], r1[32],
           r2[31:0], r2[32], nm);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [17];
    logic [31:0] iw5;
    logic [31:0] iw255;
    logic [32:0] r;
    logic we;
    logic [1:0] sz;
    logic [31:0] a;

    iw5 = init_word(5);
    iw255 = init_word(255);
    tbl[0]  = '{1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0};
    tbl[1]  = '{0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0};
    tbl[2]  = '{0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFFDE, 0};
    tbl[3]  = '{0, 2'b00, 1, 32'h13, 32'h0, 32'h000000DE, 0};
    tbl[4]  = '{0, 2'b01, 0, 32'h10, 32'h0, 32'hFFFFBEEF, 0};
    tbl[5]  = '{0, 2'b01, 1, 32'h12, 32'h0, 32'h0000DEAD, 0};
    tbl[6]  = '{1, 2'b00, 0, 32'h11, 32'hAABBCC55, 32'h0, 0};
    tbl[7]  = '{0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD55EF, 0};
    tbl[8]  = '{0, 2'b10, 0, 32'h12, 32'h0, 32'h0, 1};
    tbl[9]  = '{1, 2'b10, 0, 32'h400, 32'h11111111, 32'h0, 1};
    tbl[10] = '{1, 2'b01, 0, 32'h13, 32'h22222222, 32'h0, 1};
    tbl[11] = '{0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1};
    tbl[12] = '{0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD55EF, 0};
    tbl[13] = '{0, 2'b10, 0, 32'h3FC, 32'h0, iw255, 0};
    tbl[14] = '{1, 2'b01, 0, 32'h16, 32'h1234CAFE, 32'h0, 0};
    tbl[15] = '{0, 2'b10, 0, 32'h14, 32'h0,
                {16'hCAFE, iw5[15:0]}, 0};
    tbl[16] = '{0, 2'b01, 0, 32'h16, 32'h0, 32'hFFFFCAFE, 0};

    // reset state, with a request pending
    t_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst rdy", 32'(b2.req_ready), 32'd1);
    chk("rst v", 32'(b2.resp_valid), 32'd0);
    chk("rst d", b2.resp_rdata, 32'd0);
    chk("rst e", 32'(b2.resp_err), 32'd0);
    chk("rst stall", 32'(b2.stall), 32'd1);
    chk("rst v1", 32'(b1.resp_valid), 32'd0);
    t_valid = 1'b0;
    #1;
    chk("rst stall0", 32'(b2.stall), 32'd0);
    @(negedge clk);
    t_rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("idle v", 32'(b2.resp_valid), 32'd0);

    for (int w = 0; w < 256; w++)
      do_req(1, 2'b10, 0, 32'(w * 4), init_word(w),
             32'd0, 0, 32'd0, 0, $sformatf("init%0d", w));

    for (int i = 0; i < 17; i++)
      do_req(tbl[i].we, tbl[i].sz, tbl[i].un, tbl[i].a,
             tbl[i].wd, tbl[i].exp, tbl[i].err,
             tbl[i].exp, tbl[i].err, $sformatf("vec%0d", i));

    // back-to-back loads on the LATENCY=2 responder
    r = ref_resp(1, 0, 2'b10, 0, 32'h14);
    @(negedge clk);
    t_valid = 1'b1;
    t_we = 1'b0;
    t_size = 2'b10;
    t_uns = 1'b0;
    t_addr = 32'h14;
    #1;
    chk("b2b idle rdy", 32'(b2.req_ready), 32'd1);
    chk("b2b idle stall", 32'(b2.stall), 32'd1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk("b2b wait rdy", 32'(b2.req_ready), 32'd0);
      chk("b2b wait stall", 32'(b2.stall), 32'd1);
      chk("b2b wait v", 32'(b2.resp_valid), 32'd0);
      @(negedge clk);
      #1;
      chk("b2b resp rdy", 32'(b2.req_ready), 32'd0);
      chk("b2b resp stall", 32'(b2.stall), 32'd0);
      chk("b2b resp v", 32'(b2.resp_valid), 32'd1);
      chk("b2b resp d", b2.resp_rdata, r[31:0]);
      @(negedge clk);
      #1;
      chk("b2b next rdy", 32'(b2.req_ready), 32'd1);
      chk("b2b next stall", 32'(b2.stall), 32'd1);
    end
    t_valid = 1'b0;
    repeat (3) @(negedge clk);

    // reset mid-WAIT (and mid-RESP for LATENCY=1)
    @(negedge clk);
    t_valid = 1'b1;
    t_we = 1'b1;
    t_size = 2'b10;
    t_addr = 32'h20;
    t_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    t_valid = 1'b0;
    #1;
    chk("mid v1", 32'(b1.resp_valid), 32'd1);
    t_rst = 1'b0;
    #1;
    chk("mid v1 drop", 32'(b1.resp_valid), 32'd0);
    chk("mid v2", 32'(b2.resp_valid), 32'd0);
    chk("mid rdy2", 32'(b2.req_ready), 32'd1);
    chk("mid d2", b2.resp_rdata, 32'd0);
    chk("mid e2", 32'(b2.resp_err), 32'd0);
    @(negedge clk);
    t_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("post rst v2", 32'(b2.resp_valid), 32'd0);
    end
    mdl_store(0, 2'b10, 32'h20, 32'h12345678);
    do_ref(0, 2'b10, 0, 32'h20, 32'h0, "rst load");

    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      a = 32'($urandom_range(0, 1100));
      if ($urandom_range(0, 19) == 0) a = $urandom;
      do_ref(we, sz, 1'($urandom), a, $urandom,
             $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
